// File: rtl/mem_writeback_ctrl_if.sv
// Pipeline-input and data-memory handshake bundle for mem_writeback_ctrl.
// slave = the controller's view, master = the surrounding pipeline/memory view.
interface mem_writeback_ctrl_if;
    logic        IN_VALID;
    logic        IN_READY;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNCT3;
    logic [4:0]  RD;
    logic [31:0] ALU_RESULT;
    logic [31:0] RS2_DATA;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_BE;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
    logic        RD_WE;
    logic [4:0]  RD_ADDR;
    logic [31:0] RD_DATA;
    logic        ERR_ACCESS;
    logic        ERR_TIMEOUT;

    modport slave (
        input  IN_VALID, OPCODE, FUNCT3, RD, ALU_RESULT, RS2_DATA, MEM_ACK, MEM_RDATA,
        output IN_READY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE,
               RD_WE, RD_ADDR, RD_DATA, ERR_ACCESS, ERR_TIMEOUT
    );

    modport master (
        output IN_VALID, OPCODE, FUNCT3, RD, ALU_RESULT, RS2_DATA, MEM_ACK, MEM_RDATA,
        input  IN_READY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE,
               RD_WE, RD_ADDR, RD_DATA, ERR_ACCESS, ERR_TIMEOUT
    );
endinterface

// File: rtl/mem_writeback_ctrl.sv
// Writeback / load-store back end: register writeback, req/ack data memory, load extract, store BE.
// Optional MEMWB_TIMEOUT_EN aborts a memory request after TIMEOUT_CYCLES cycles without ack.
module mem_writeback_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    mem_writeback_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MEM, WB, ERR} state_e;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        rd_we_q, rd_we_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        err_access_q, err_access_d;
    logic        err_timeout_q, err_timeout_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;

`ifdef MEMWB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    logic        is_alu, is_load, is_store, legal, aligned;
    logic [1:0]  in_off;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = d[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return d;
        endcase
    endfunction

    always_comb begin
        in_off   = bus.ALU_RESULT[1:0];
        is_alu   = bus.OPCODE inside {OP_IMM, OP_REG, OP_LUI, OP_AUIPC};
        is_load  = (bus.OPCODE == OP_LOAD);
        is_store = (bus.OPCODE == OP_STORE);
        legal    = is_load ? (bus.FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                           : (bus.FUNCT3 inside {3'b000, 3'b001, 3'b010});
        case (bus.FUNCT3[1:0])
            2'b01:   aligned = ~in_off[0];
            2'b10:   aligned = (in_off == 2'b00);
            default: aligned = 1'b1;
        endcase
        case (bus.FUNCT3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << in_off;
                st_wdata = {4{bus.RS2_DATA[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << in_off;
                st_wdata = {2{bus.RS2_DATA[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = bus.RS2_DATA;
            end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        rd_addr_d     = rd_addr_q;
        rd_data_d     = rd_data_q;
        funct3_d      = funct3_q;
        off_d         = off_q;
        rd_we_d       = 1'b0;
        err_access_d  = 1'b0;
        err_timeout_d = 1'b0;
`ifdef MEMWB_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            IDLE: if (bus.IN_VALID) begin
                if (is_alu) begin
                    state_d   = WB;
                    rd_we_d   = |bus.RD;
                    rd_addr_d = bus.RD;
                    rd_data_d = bus.ALU_RESULT;
                end else if (is_load || is_store) begin
                    if (legal && aligned) begin
                        state_d     = MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {bus.ALU_RESULT[31:2], 2'b00};
                        mem_be_d    = is_store ? st_be : 4'b0000;
                        mem_wdata_d = is_store ? st_wdata : 32'd0;
                        rd_addr_d   = bus.RD;
                        funct3_d    = bus.FUNCT3;
                        off_d       = in_off;
`ifdef MEMWB_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else begin
                        state_d      = ERR;
                        err_access_d = 1'b1;
                    end
                end
            end
            MEM: begin
`ifdef MEMWB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                // ack is checked first so an ack on the limit cycle still completes normally
                if (bus.MEM_ACK) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'b0000;
                    if (mem_we_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = WB;
                        rd_we_d   = |rd_addr_q;
                        rd_data_d = load_extract(funct3_q, off_q, bus.MEM_RDATA);
                    end
                end
`ifdef MEMWB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d       = IDLE;
                    mem_req_d     = 1'b0;
                    mem_we_d      = 1'b0;
                    mem_be_d      = 4'b0000;
                    err_timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            rd_we_q       <= 1'b0;
            rd_addr_q     <= '0;
            rd_data_q     <= '0;
            err_access_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            funct3_q      <= '0;
            off_q         <= '0;
`ifdef MEMWB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            rd_we_q       <= rd_we_d;
            rd_addr_q     <= rd_addr_d;
            rd_data_q     <= rd_data_d;
            err_access_q  <= err_access_d;
            err_timeout_q <= err_timeout_d;
            funct3_q      <= funct3_d;
            off_q         <= off_d;
`ifdef MEMWB_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign bus.IN_READY    = (state_q == IDLE);
    assign bus.MEM_REQ     = mem_req_q;
    assign bus.MEM_WE      = mem_we_q;
    assign bus.MEM_ADDR    = mem_addr_q;
    assign bus.MEM_WDATA   = mem_wdata_q;
    assign bus.MEM_BE      = mem_be_q;
    assign bus.RD_WE       = rd_we_q;
    assign bus.RD_ADDR     = rd_addr_q;
    assign bus.RD_DATA     = rd_data_q;
    assign bus.ERR_ACCESS  = err_access_q;
`ifdef MEMWB_TIMEOUT_EN
    assign bus.ERR_TIMEOUT = err_timeout_q;
`else
    assign bus.ERR_TIMEOUT = 1'b0;
`endif
endmodule

// File: tb/tb_mem_writeback_ctrl.sv
// Directed bench for mem_writeback_ctrl; register writebacks go through a queue scoreboard.
module tb_mem_writeback_ctrl;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;
    wb_t  wb_q[$];

    mem_writeback_ctrl_if bus();

    mem_writeback_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample_wb();
        wb_t e;
        if (bus.RD_WE === 1'b1) begin
            chk("wb_expected", 32'(wb_q.size() != 0), 32'd1);
            if (wb_q.size() != 0) begin
                e = wb_q.pop_front();
                chk("wb_addr", 32'(bus.RD_ADDR), 32'(e.addr));
                chk("wb_data", bus.RD_DATA, e.data);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        sample_wb();
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rs2);
        int n = 0;
        while (bus.IN_READY !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        chk("issue_ready", 32'(bus.IN_READY), 32'd1);
        bus.OPCODE = op; bus.FUNCT3 = f3; bus.RD = rd;
        bus.ALU_RESULT = alu; bus.RS2_DATA = rs2;
        bus.IN_VALID = 1'b1;
        cyc();
        bus.IN_VALID = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] rdata, input logic [31:0] exp);
        if (rd != 5'd0) wb_q.push_back('{addr: rd, data: exp});
        issue(OP_LOAD, f3, rd, addr, 32'h0);
        chk({tag, "_req"}, 32'(bus.MEM_REQ), 32'd1);
        chk({tag, "_we"}, 32'(bus.MEM_WE), 32'd0);
        chk({tag, "_addr"}, bus.MEM_ADDR, {addr[31:2], 2'b00});
        chk({tag, "_be"}, 32'(bus.MEM_BE), 32'd0);
        cyc();
        cyc();
        chk({tag, "_req_held"}, 32'(bus.MEM_REQ), 32'd1);
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = rdata;
        cyc();
        bus.MEM_ACK = 1'b0; bus.MEM_RDATA = 32'hA5A5_A5A5;
        chk({tag, "_rd_we"}, 32'(bus.RD_WE), 32'(rd != 5'd0));
        chk({tag, "_req_drop"}, 32'(bus.MEM_REQ), 32'd0);
        cyc();
        chk({tag, "_ready"}, 32'(bus.IN_READY), 32'd1);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [3:0] be, input logic [31:0] wdata);
        issue(OP_STORE, f3, 5'd9, addr, rs2);
        chk({tag, "_we"}, 32'(bus.MEM_WE), 32'd1);
        chk({tag, "_addr"}, bus.MEM_ADDR, {addr[31:2], 2'b00});
        chk({tag, "_be"}, 32'(bus.MEM_BE), 32'(be));
        chk({tag, "_wdata"}, bus.MEM_WDATA, wdata);
        cyc();
        cyc();
        chk({tag, "_held"}, {bus.MEM_WDATA[27:0], bus.MEM_BE}, {wdata[27:0], be});
        chk({tag, "_req_held"}, 32'(bus.MEM_REQ), 32'd1);
        bus.MEM_ACK = 1'b1;
        cyc();
        bus.MEM_ACK = 1'b0;
        chk({tag, "_req_drop"}, 32'(bus.MEM_REQ), 32'd0);
        chk({tag, "_no_wb"}, 32'(bus.RD_WE), 32'd0);
        chk({tag, "_ready"}, 32'(bus.IN_READY), 32'd1);
    endtask

    task automatic do_err(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] addr);
        issue(op, f3, 5'd3, addr, 32'h1111_2222);
        chk({tag, "_err"}, 32'(bus.ERR_ACCESS), 32'd1);
        chk({tag, "_noreq"}, 32'(bus.MEM_REQ), 32'd0);
        chk({tag, "_busy"}, 32'(bus.IN_READY), 32'd0);
        cyc();
        chk({tag, "_err_end"}, 32'(bus.ERR_ACCESS), 32'd0);
        chk({tag, "_ready"}, 32'(bus.IN_READY), 32'd1);
        chk({tag, "_noreq2"}, 32'(bus.MEM_REQ), 32'd0);
    endtask

    initial begin
        int n;
        bus.IN_VALID = 1'b0; bus.OPCODE = '0; bus.FUNCT3 = '0; bus.RD = '0;
        bus.ALU_RESULT = '0; bus.RS2_DATA = '0; bus.MEM_ACK = 1'b0; bus.MEM_RDATA = '0;

        // reset
        cyc();
        cyc();
        chk("rst_ready", 32'(bus.IN_READY), 32'd1);
        chk("rst_outs", {bus.MEM_REQ, bus.MEM_WE, bus.MEM_BE, bus.RD_WE, bus.ERR_ACCESS, bus.ERR_TIMEOUT},
            32'd0);
        chk("rst_addr", bus.MEM_ADDR, 32'd0);
        chk("rst_rd_data", bus.RD_DATA, 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_ready", 32'(bus.IN_READY), 32'd1);

        // ALU writeback and RD=0 suppression
        wb_q.push_back('{addr: 5'd5, data: 32'h0000_1234});
        issue(OP_IMM, 3'b000, 5'd5, 32'h0000_1234, 32'h0);
        chk("addi_rd_we", 32'(bus.RD_WE), 32'd1);
        chk("addi_busy", 32'(bus.IN_READY), 32'd0);
        cyc();
        chk("addi_we_end", 32'(bus.RD_WE), 32'd0);
        chk("addi_ready", 32'(bus.IN_READY), 32'd1);
        issue(OP_IMM, 3'b000, 5'd0, 32'h0000_1234, 32'h0);
        chk("addi_x0_no_we", 32'(bus.RD_WE), 32'd0);
        cyc();
        chk("addi_x0_ready", 32'(bus.IN_READY), 32'd1);

        // loads
        do_load("lb",  3'b000, 5'd7,  32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 5'd8,  32'h0000_0103, 32'h80FF_0000, 32'h0000_0080);
        do_load("lh",  3'b001, 5'd10, 32'h0000_0102, 32'h8001_7FFF, 32'hFFFF_8001);
        do_load("lhu", 3'b101, 5'd11, 32'h0000_0100, 32'h8001_F7FF, 32'h0000_F7FF);
        do_load("lw",  3'b010, 5'd12, 32'h0000_0104, 32'h1234_5678, 32'h1234_5678);
        do_load("lb0", 3'b000, 5'd13, 32'h0000_0101, 32'h0000_7F00, 32'h0000_007F);

        // stores
        do_store("sh", 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store("sb", 3'b000, 32'h0000_0001, 32'h1234_5678, 4'b0010, 32'h7878_7878);
        do_store("sw", 3'b010, 32'h0000_0300, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE);

        // access errors
        do_err("lw_mis",  OP_LOAD,  3'b010, 32'h0000_0101);
        do_err("st_f3_3", OP_STORE, 3'b011, 32'h0000_0200);
        do_err("lh_mis",  OP_LOAD,  3'b001, 32'h0000_0103);
        do_err("ld_f3_6", OP_LOAD,  3'b110, 32'h0000_0100);

        // unknown opcode is consumed silently
        issue(OP_BR, 3'b000, 5'd4, 32'h0000_0040, 32'h0);
        chk("other_ready", 32'(bus.IN_READY), 32'd1);
        chk("other_quiet", {bus.MEM_REQ, bus.RD_WE, bus.ERR_ACCESS}, 32'd0);

        // stray ack in IDLE
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hFFFF_FFFF;
        cyc();
        bus.MEM_ACK = 1'b0;
        cyc();
        chk("idle_ack_ignored", {bus.RD_WE, bus.MEM_REQ}, 32'd0);

        // upstream holds IN_VALID while busy: accepted only once back in IDLE
        wb_q.push_back('{addr: 5'd4, data: 32'hCAFE_F00D});
        wb_q.push_back('{addr: 5'd3, data: 32'h0000_0055});
        issue(OP_LOAD, 3'b010, 5'd4, 32'h0000_0010, 32'h0);
        bus.OPCODE = OP_IMM; bus.FUNCT3 = 3'b000; bus.RD = 5'd3; bus.ALU_RESULT = 32'h55;
        bus.IN_VALID = 1'b1;
        cyc();
        chk("hold_req", 32'(bus.MEM_REQ), 32'd1);
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hCAFE_F00D;
        cyc();
        bus.MEM_ACK = 1'b0;
        chk("hold_load_wb", 32'(bus.RD_ADDR), 32'd4);
        cyc();
        chk("hold_idle", 32'(bus.IN_READY), 32'd1);
        cyc();
        bus.IN_VALID = 1'b0;
        chk("hold_alu_wb", {bus.RD_WE, 3'b000, bus.RD_ADDR}, {1'b1, 3'b000, 5'd3});
        cyc();

        // reset in the middle of a pending load, then a late ack
        issue(OP_LOAD, 3'b010, 5'd9, 32'h0000_0020, 32'h0);
        chk("rstmid_req", 32'(bus.MEM_REQ), 32'd1);
        rst_n = 1'b0;
        cyc();
        chk("rstmid_req_drop", 32'(bus.MEM_REQ), 32'd0);
        chk("rstmid_ready", 32'(bus.IN_READY), 32'd1);
        rst_n = 1'b1;
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h0BAD_0BAD;
        cyc();
        bus.MEM_ACK = 1'b0;
        chk("rstmid_late_ack", {bus.RD_WE, bus.MEM_REQ}, 32'd0);
        cyc();
        chk("rstmid_late_ack2", 32'(bus.RD_WE), 32'd0);
        chk("rstmid_ready2", 32'(bus.IN_READY), 32'd1);

`ifdef MEMWB_TIMEOUT_EN
        // no ack: request held exactly 4 cycles, then timeout pulse
        issue(OP_LOAD, 3'b010, 5'd14, 32'h0000_0040, 32'h0);
        n = 0;
        while (bus.MEM_REQ === 1'b1 && n < 20) begin
            n++;
            cyc();
        end
        chk("to_req_cycles", 32'(n), 32'd4);
        chk("to_err_pulse", 32'(bus.ERR_TIMEOUT), 32'd1);
        chk("to_idle", 32'(bus.IN_READY), 32'd1);
        cyc();
        chk("to_err_end", 32'(bus.ERR_TIMEOUT), 32'd0);
        chk("to_no_wb", 32'(bus.RD_WE), 32'd0);

        // ack on the limit cycle completes normally
        wb_q.push_back('{addr: 5'd15, data: 32'h0000_0777});
        issue(OP_LOAD, 3'b010, 5'd15, 32'h0000_0044, 32'h0);
        cyc();
        cyc();
        cyc();
        chk("to_lim_req", 32'(bus.MEM_REQ), 32'd1);
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h0000_0777;
        cyc();
        bus.MEM_ACK = 1'b0;
        chk("to_lim_wb", 32'(bus.RD_WE), 32'd1);
        chk("to_lim_no_err", 32'(bus.ERR_TIMEOUT), 32'd0);
        cyc();
        chk("to_lim_no_err2", 32'(bus.ERR_TIMEOUT), 32'd0);
`else
        // without the timeout feature the request waits indefinitely
        wb_q.push_back('{addr: 5'd14, data: 32'h0000_0999});
        issue(OP_LOAD, 3'b010, 5'd14, 32'h0000_0040, 32'h0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.MEM_REQ === 1'b1 && bus.ERR_TIMEOUT === 1'b0) n++;
            cyc();
        end
        chk("noto_wait", 32'(n), 32'd12);
        chk("noto_req_still", 32'(bus.MEM_REQ), 32'd1);
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h0000_0999;
        cyc();
        bus.MEM_ACK = 1'b0;
        chk("noto_wb", 32'(bus.RD_WE), 32'd1);
        chk("noto_err", 32'(bus.ERR_TIMEOUT), 32'd0);
        cyc();
`endif

        chk("wb_drain", 32'(wb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
